mem_access_ctrl: RTL and testbench

Load/store initiator that sits between the CPU datapath and the 32×32 data memory. Accepts one byte, halfword or word access per request, drives the memory's fully registered port (address, write enable and data sampled on the clock edge; read data registered, available two cycles after the address), and performs read-modify-write for sub-word stores. Returns sign- or zero-extended load data and flags misaligned or out-of-range accesses, holding the pipeline via `busy`.

---
 rtl/mem_access_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a fully registered single-port data memory.
// Handles byte/half/word accesses, sub-word read-modify-write and access checking.
module mem_access_ctrl #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout
);

    typedef enum logic [2:0] {IDLE, RADDR, RWAIT, RDATA, WRITE, DONE} state_t;

    state_t      state;
    logic        wr_q, uns_q;
    logic [1:0]  size_q, lane_q;
    logic [15:0] wdata_q;

    logic        bad;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld, merged;

    always_comb begin
        bad = (size == 2'b11)
            || (size == 2'b01 && addr[0])
            || (size == 2'b10 && addr[1:0] != 2'b00)
            || (addr[31:DEPTH_LOG2+2] != '0);
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        lb = mem_dataout[{lane_q, 3'b000} +: 8];
        lh = mem_dataout[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   ld = uns_q ? {24'b0, lb} : {{24{lb[7]}}, lb};
            2'b01:   ld = uns_q ? {16'b0, lh} : {{16{lh[15]}}, lh};
            default: ld = mem_dataout;
        endcase
        merged = mem_dataout;
        if (size_q == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_we     <= 1'b0;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_datain <= '0;
            wr_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
        end else begin
            done   <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    wr_q     <= wr;
                    uns_q    <= uns;
                    size_q   <= size;
                    lane_q   <= addr[1:0];
                    wdata_q  <= wdata[15:0];
                    mem_addr <= {addr[31:2], 2'b00};
                    busy     <= 1'b1;
                    err      <= bad;
                    if (bad) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (wr && size == 2'b10) begin
                        state      <= WRITE;
                        mem_we     <= 1'b1;
                        mem_datain <= wdata;
                    end else begin
                        state <= RADDR;
                    end
                end
                RADDR: state <= RWAIT;
                RWAIT: state <= RDATA;
                RDATA: begin
                    if (wr_q) begin
                        mem_datain <= merged;
                        mem_we     <= 1'b1;
                        state      <= WRITE;
                    end else begin
                        rdata <= ld;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                WRITE: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: vector table plus scoreboard, with a two-stage
// registered memory model and a reference memory image.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clrn, req, wr, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata, mem_addr, mem_datain, mem_dataout;

    mem_access_ctrl #(.DEPTH_LOG2(5)) dut (
        .clk(clk), .clrn(clrn), .req(req), .wr(wr), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    // Memory: address registered, then output registered (2-cycle read).
    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    logic [4:0]  a_q;
    always @(posedge clk) begin
        a_q         <= mem_addr[6:2];
        mem_dataout <= mem[a_q];
        if (mem_we) mem[mem_addr[6:2]] <= mem_datain;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          we_lat;
        logic [31:0] wa;
    } exp_t;

    exp_t        sbq[$];
    exp_t        cur;
    int          n_cmp = 0, n_bad = 0;
    int          done_cnt = 0, acc_cnt = 0;
    int          t_acc = 0, t_prev = 0, wr_seen = 0, lat = 0;
    logic        active = 1'b0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: tracks the accepted request and scores it when done appears.
    initial begin
        forever begin
            @(negedge clk);
            if (!clrn) begin
                active = 1'b0;
            end else begin
                if (active) begin
                    lat = cyc - t_acc;
                    if (mem_we) begin
                        wr_seen++;
                        chk("we_cycle", lat, cur.we_lat);
                        chk("we_addr", mem_addr, cur.wa);
                    end
                    if (done) begin
                        chk("done_lat", lat, cur.lat);
                        chk("err", err, cur.err);
                        chk("rdata", rdata, cur.rdata);
                        chk("write_count", wr_seen, (cur.we_lat >= 0) ? 1 : 0);
                        void'(sbq.pop_front());
                        active = 1'b0;
                        done_cnt++;
                    end else begin
                        chk("busy_active", busy, 1);
                    end
                end else begin
                    chk("idle_done", done, 0);
                    chk("idle_we", mem_we, 0);
                    chk("idle_busy", busy, 0);
                end
                if (req && !busy) begin
                    if (sbq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_accept: got accept expected none (cycle %0d)", cyc);
                    end else begin
                        cur     = sbq[0];
                        active  = 1'b1;
                        t_prev  = t_acc;
                        t_acc   = cyc;
                        wr_seen = 0;
                        acc_cnt++;
                    end
                end
            end
        end
    end

    task automatic push(input vec_t v);
        exp_t e;
        int   ln;
        e.err    = v.err;
        e.lat    = v.lat;
        e.we_lat = (v.wr && !v.err) ? v.lat - 1 : -1;
        e.wa     = {v.addr[31:2], 2'b00};
        if (!v.wr && !v.err) last_rd = v.rdata;
        e.rdata  = last_rd;
        if (v.wr && !v.err) begin
            ln = int'(v.addr[1:0]);
            case (v.size)
                2'b00:   ref_mem[v.addr[6:2]][8*ln +: 8] = v.wdata[7:0];
                2'b01:   ref_mem[v.addr[6:2]][8*ln +: 16] = v.wdata[15:0];
                default: ref_mem[v.addr[6:2]] = v.wdata;
            endcase
        end
        sbq.push_back(e);
    endtask

    task automatic drive(input vec_t v);
        wr = v.wr; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 40) begin
            @(posedge clk);
            k++;
        end
        chk("completed", done_cnt >= target, 1);
    endtask

    task automatic issue(input vec_t v);
        int d0 = done_cnt;
        push(v);
        @(posedge clk); #1;
        drive(v);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        wait_done(d0 + 1);
    endtask

    vec_t tbl[22];
    vec_t v;
    int   d0, a0, k;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        //            wr size   uns addr          wdata          err rdata          lat
        tbl[0]  = '{1, 2'b10, 0, 32'h08,       32'hDEADBEEF, 0, 32'h0,        2};
        tbl[1]  = '{0, 2'b10, 0, 32'h08,       32'h0,        0, 32'hDEADBEEF, 4};
        tbl[2]  = '{0, 2'b00, 0, 32'h0B,       32'h0,        0, 32'hFFFFFFDE, 4};
        tbl[3]  = '{0, 2'b00, 1, 32'h0B,       32'h0,        0, 32'h000000DE, 4};
        tbl[4]  = '{0, 2'b01, 0, 32'h08,       32'h0,        0, 32'hFFFFBEEF, 4};
        tbl[5]  = '{0, 2'b01, 1, 32'h0A,       32'h0,        0, 32'h0000DEAD, 4};
        tbl[6]  = '{1, 2'b00, 0, 32'h09,       32'hFFFFFF12, 0, 32'h0,        5};
        tbl[7]  = '{0, 2'b10, 0, 32'h08,       32'h0,        0, 32'hDEAD12EF, 4};
        tbl[8]  = '{1, 2'b01, 0, 32'h0A,       32'hABCD5566, 0, 32'h0,        5};
        tbl[9]  = '{0, 2'b10, 0, 32'h08,       32'h0,        0, 32'h556612EF, 4};
        tbl[10] = '{0, 2'b00, 0, 32'h08,       32'h0,        0, 32'hFFFFFFEF, 4};
        tbl[11] = '{0, 2'b01, 0, 32'h0A,       32'h0,        0, 32'h00005566, 4};
        tbl[12] = '{0, 2'b01, 0, 32'h03,       32'h0,        1, 32'h0,        1};
        tbl[13] = '{1, 2'b10, 0, 32'h06,       32'h11111111, 1, 32'h0,        1};
        tbl[14] = '{1, 2'b11, 0, 32'h08,       32'h22222222, 1, 32'h0,        1};
        tbl[15] = '{0, 2'b10, 0, 32'h80,       32'h0,        1, 32'h0,        1};
        tbl[16] = '{1, 2'b10, 0, 32'h80,       32'h12345678, 1, 32'h0,        1};
        tbl[17] = '{1, 2'b10, 0, 32'h7C,       32'h80000001, 0, 32'h0,        2};
        tbl[18] = '{0, 2'b00, 0, 32'h7F,       32'h0,        0, 32'hFFFFFF80, 4};
        tbl[19] = '{0, 2'b00, 1, 32'h7C,       32'h0,        0, 32'h00000001, 4};
        tbl[20] = '{0, 2'b00, 0, 32'h80000008, 32'h0,        1, 32'h0,        1};
        tbl[21] = '{0, 2'b10, 0, 32'h08,       32'h0,        0, 32'h556612EF, 4};

        clrn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_datain", mem_datain, 0);
        clrn = 1'b1;

        for (int i = 0; i < 22; i++) issue(tbl[i]);

        // A store offered while a load is in flight must be dropped.
        v = '{0, 2'b10, 0, 32'h08, 32'h0, 0, 32'h556612EF, 4};
        d0 = done_cnt;
        push(v);
        @(posedge clk); #1;
        drive(v);
        req = 1'b1;
        @(posedge clk); #1;
        wr = 1'b1; wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 1'b0;
        wait_done(d0 + 1);
        repeat (6) @(posedge clk);

        // req held high: second acceptance lands in the IDLE cycle after DONE.
        v = '{0, 2'b00, 1, 32'h0A, 32'h0, 0, 32'h00000066, 4};
        d0 = done_cnt;
        a0 = acc_cnt;
        push(v);
        push(v);
        @(posedge clk); #1;
        drive(v);
        req = 1'b1;
        k = 0;
        while (acc_cnt < a0 + 2 && k < 40) begin
            @(posedge clk);
            k++;
        end
        #1;
        req = 1'b0;
        chk("b2b_accepts", acc_cnt - a0, 2);
        chk("b2b_gap", t_acc - t_prev, 5);
        wait_done(d0 + 2);

        // Reset during RWAIT of a byte store: abandoned, no write, no done.
        v = '{1, 2'b00, 0, 32'h09, 32'h000000AA, 0, 32'h0, 5};
        push(v);
        ref_mem[2] = 32'h556612EF;
        @(posedge clk); #1;
        drive(v);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        clrn = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_err", err, 0);
        chk("mid_we", mem_we, 0);
        chk("mid_rdata", rdata, 0);
        chk("mid_addr", mem_addr, 0);
        chk("mid_datain", mem_datain, 0);
        @(posedge clk); #1;
        clrn = 1'b1;
        sbq.delete();
        repeat (8) @(posedge clk);
        #1;
        chk("rst_word08", mem[2], 32'h556612EF);

        // Reset asserted inside WRITE: mem_we must fall without waiting for an edge.
        v = '{1, 2'b10, 0, 32'h0C, 32'h33333333, 0, 32'h0, 2};
        sbq.push_back('{1'b0, 32'h0, 2, 1, 32'h0C});
        @(posedge clk); #1;
        drive(v);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("write_we_high", mem_we, 1);
        clrn = 1'b0;
        #1;
        chk("async_we_drop", mem_we, 0);
        @(posedge clk); #1;
        clrn = 1'b1;
        sbq.delete();
        repeat (6) @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
        chk("sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
